// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB register bank.
//   opb_state_e : bus handshake state (IDLE -> ACK -> TURN)
//   lane_mask   : expands a byte-enable vector into a 32-bit write mask
//   be_merge    : byte-enable merge of new write data into an old word
// Byte-enable vectors here use register bit order: be[k] covers bits [8k+7:8k],
// so OPB_BE[0] (big-endian lane 0) lands on be[3].
package opb_reg_pkg;

   localparam int unsigned OPB_DW         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_TURN = 2'd2
   } opb_state_e;

   // One byte-enable bit per 8-bit lane of the register word.
   function automatic logic [OPB_DW-1:0] lane_mask(input logic [BYTES_PER_WORD-1:0] be);
      logic [OPB_DW-1:0] mask;
      mask = '0;
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
         mask[8*k +: 8] = {8{be[k]}};
      end
      return mask;
   endfunction

   // Enabled lanes take the new data, the rest keep the old word.
   function automatic logic [OPB_DW-1:0] be_merge(input logic [OPB_DW-1:0]         old_word,
                                                  input logic [OPB_DW-1:0]         new_word,
                                                  input logic [BYTES_PER_WORD-1:0] be);
      logic [OPB_DW-1:0] mask;
      mask = lane_mask(be);
      return (old_word & ~mask) | (new_word & mask);
   endfunction

endpackage

// File: rtl/opb_slave_handshake.sv
// OPB slave handshake: address-window decode, IDLE/ACK/TURN sequencing and
// capture of the transaction attributes.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_select, i_rnw   OPB select and read/not-write
//   i_addr            byte address (register bit order, MSB = OPB_ABus[0])
//   i_be, i_wdata     byte enables / write data in register bit order
//   o_rd_en_c         read captured on this edge (sample read data now)
//   o_cap_idx_c       word index of the address currently on the bus
//   o_ack             transfer acknowledge, high for the ACK cycle only
//   o_wr_en           ACK cycle of a write to a control register
//   o_idx, o_be, o_wdata  latched word index, byte enables, write data
module opb_slave_handshake
   import opb_reg_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter logic [31:0] BASEADDR = 32'h01001100,
   parameter logic [31:0] HIGHADDR = 32'h010011FF,
   parameter int unsigned NUM_CTRL = 4,
   parameter int unsigned IDX_W    = AW - 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_select,
   input  logic                      i_rnw,
   input  logic [AW-1:0]             i_addr,
   input  logic [BYTES_PER_WORD-1:0] i_be,
   input  logic [OPB_DW-1:0]         i_wdata,
   output logic                      o_rd_en_c,
   output logic [IDX_W-1:0]          o_cap_idx_c,
   output logic                      o_ack,
   output logic                      o_wr_en,
   output logic [IDX_W-1:0]          o_idx,
   output logic [BYTES_PER_WORD-1:0] o_be,
   output logic [OPB_DW-1:0]         o_wdata
);

   opb_state_e                r_state;
   opb_state_e                w_state_nxt;
   logic                      w_capture;
   logic                      w_hit;
   logic [AW-1:0]             w_base;
   logic [AW-1:0]             w_high;
   logic [AW-1:0]             w_offset;
   logic [1:0]                w_unused_lsb;
   logic                      r_ack;
   logic                      r_wr_en;
   logic [IDX_W-1:0]          r_idx;
   logic [BYTES_PER_WORD-1:0] r_be;
   logic [OPB_DW-1:0]         r_wdata;

   // Window decode; the byte offset within a word is ignored.
   assign w_base       = AW'(BASEADDR);
   assign w_high       = AW'(HIGHADDR);
   assign w_offset     = i_addr - w_base;
   assign w_hit        = i_select && (i_addr >= w_base) && (i_addr <= w_high);
   assign o_cap_idx_c  = w_offset[AW-1:2];
   assign w_unused_lsb = w_offset[1:0];

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; hits are only looked at in IDLE so a held select cannot retrigger.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK:  w_state_nxt = ST_TURN;
         ST_TURN: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_rd_en_c = w_capture && i_rnw;

   // Transaction capture; ack and write enable are valid for the ACK cycle only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack   <= 1'b0;
         r_wr_en <= 1'b0;
         r_idx   <= '0;
         r_be    <= '0;
         r_wdata <= '0;
      end else begin
         r_ack   <= w_capture;
         r_wr_en <= w_capture && !i_rnw && (o_cap_idx_c < IDX_W'(NUM_CTRL));
         if (w_capture) begin
            r_idx   <= o_cap_idx_c;
            r_be    <= i_be;
            r_wdata <= i_wdata;
         end
      end
   end

   assign o_ack   = r_ack;
   assign o_wr_en = r_wr_en;
   assign o_idx   = r_idx;
   assign o_be    = r_be;
   assign o_wdata = r_wdata;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave register bank: NUM_CTRL writable control words followed by
// NUM_STAT read-only status words in one address window.
// Ports:
//   OPB_Clk, OPB_Rst     clock, synchronous active-high reset
//   OPB_ABus/BE/DBus     address, byte enables, write data (big-endian bit order)
//   OPB_RNW, OPB_select  read/not-write, transaction valid
//   OPB_seqAddr          unused
//   Sl_DBus              read data, zero outside the ack cycle
//   Sl_xferAck           one-cycle acknowledge
//   Sl_errAck/retry/toutSup  tied low
//   user_data_out        control word i on [32i+31:32i]
//   user_wr_stb          one-cycle pulse per written control word
//   user_data_in         status word j on [32j+31:32j]
module opb_register_bank
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01001100,
   parameter logic [31:0] C_HIGHADDR   = 32'h010011FF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter int unsigned NUM_CTRL     = 4,
   parameter int unsigned NUM_STAT     = 2,
   parameter logic [31:0] CTRL_RESET   = 32'h00000000
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
   input  logic [0:BYTES_PER_WORD-1]    OPB_BE,
   input  logic [0:OPB_DW-1]            OPB_DBus,
   input  logic                         OPB_RNW,
   input  logic                         OPB_select,
   input  logic                         OPB_seqAddr,
   output logic [0:OPB_DW-1]            Sl_DBus,
   output logic                         Sl_xferAck,
   output logic                         Sl_errAck,
   output logic                         Sl_retry,
   output logic                         Sl_toutSup,
   output logic [NUM_CTRL*OPB_DW-1:0]   user_data_out,
   output logic [NUM_CTRL-1:0]          user_wr_stb,
   input  logic [NUM_STAT*OPB_DW-1:0]   user_data_in
);

   localparam int unsigned IDX_W = C_OPB_AWIDTH - 2;

   logic [C_OPB_AWIDTH-1:0]   w_addr;
   logic [BYTES_PER_WORD-1:0] w_be;
   logic [OPB_DW-1:0]         w_wdata;
   logic                      w_unused_seq;
   logic                      w_rd_en_c;
   logic [IDX_W-1:0]          w_cap_idx_c;
   logic                      w_ack;
   logic                      w_wr_en;
   logic [IDX_W-1:0]          w_idx;
   logic [BYTES_PER_WORD-1:0] w_be_q;
   logic [OPB_DW-1:0]         w_wdata_q;
   logic [OPB_DW-1:0]         w_rd_mux;

   logic [OPB_DW-1:0]         r_ctrl [NUM_CTRL];
   logic [NUM_CTRL-1:0]       r_wr_stb;
   logic [OPB_DW-1:0]         r_rd_data;

   // Big-endian OPB vectors map MSB-to-MSB onto register bit order.
   assign w_addr       = OPB_ABus;
   assign w_be         = OPB_BE;
   assign w_wdata      = OPB_DBus;
   assign w_unused_seq = OPB_seqAddr;

   opb_slave_handshake #(
      .AW       (C_OPB_AWIDTH),
      .BASEADDR (C_BASEADDR),
      .HIGHADDR (C_HIGHADDR),
      .NUM_CTRL (NUM_CTRL),
      .IDX_W    (IDX_W)
   ) u_handshake (
      .i_clk       (OPB_Clk),
      .i_rst       (OPB_Rst),
      .i_select    (OPB_select),
      .i_rnw       (OPB_RNW),
      .i_addr      (w_addr),
      .i_be        (w_be),
      .i_wdata     (w_wdata),
      .o_rd_en_c   (w_rd_en_c),
      .o_cap_idx_c (w_cap_idx_c),
      .o_ack       (w_ack),
      .o_wr_en     (w_wr_en),
      .o_idx       (w_idx),
      .o_be        (w_be_q),
      .o_wdata     (w_wdata_q)
   );

   // Read mux over control words, then status words; unmapped indices read 0.
   always_comb begin
      w_rd_mux = '0;
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
         if (w_cap_idx_c == IDX_W'(i)) begin
            w_rd_mux = r_ctrl[i];
         end
      end
      for (int unsigned j = 0; j < NUM_STAT; j++) begin
         if (w_cap_idx_c == IDX_W'(NUM_CTRL + j)) begin
            w_rd_mux = user_data_in[OPB_DW*j +: OPB_DW];
         end
      end
   end

   // Control registers, write strobes and read-data register.
   // Read data is loaded on the capture edge so it is on the bus only during ACK.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            r_ctrl[i] <= CTRL_RESET;
         end
         r_wr_stb  <= '0;
         r_rd_data <= '0;
      end else begin
         r_wr_stb  <= '0;
         r_rd_data <= w_rd_en_c ? w_rd_mux : '0;
         for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            if (w_wr_en && (w_idx == IDX_W'(i))) begin
               r_ctrl[i]   <= be_merge(r_ctrl[i], w_wdata_q, w_be_q);
               r_wr_stb[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CTRL; g++) begin : g_out
      assign user_data_out[OPB_DW*g +: OPB_DW] = r_ctrl[g];
   end

   assign Sl_DBus     = r_rd_data;
   assign Sl_xferAck  = w_ack;
   assign Sl_errAck   = 1'b0;
   assign Sl_retry    = 1'b0;
   assign Sl_toutSup  = 1'b0;
   assign user_wr_stb = r_wr_stb;

endmodule

// File: tb/tb_opb_register_bank.sv
// Self-checking bench for opb_register_bank: directed cases plus randomized
// OPB transactions against an array-based model kept in big-endian lane order.
module tb_opb_register_bank;

   localparam logic [31:0] BASE = 32'h01001100;
   localparam logic [31:0] HIGH = 32'h010011FF;
   localparam logic [31:0] RSTV = 32'hA5A5A5A5;
   localparam int          NC   = 4;
   localparam int          NS   = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [0:31]      abus;
   logic [0:3]       be;
   logic [0:31]      dbus;
   logic             rnw;
   logic             sel;
   logic             seq;
   logic [0:31]      sl_dbus;
   logic             ack;
   logic             err_ack;
   logic             retry;
   logic             tout;
   logic [NC*32-1:0] udo;
   logic [NC-1:0]    stb;
   logic [NS*32-1:0] udi;

   int n_checks = 0;
   int n_errors = 0;

   logic [0:31] m_ctrl [NC];

   always #5 clk = ~clk;

   opb_register_bank #(
      .C_BASEADDR (BASE),
      .C_HIGHADDR (HIGH),
      .NUM_CTRL   (NC),
      .NUM_STAT   (NS),
      .CTRL_RESET (RSTV)
   ) dut (
      .OPB_Clk       (clk),
      .OPB_Rst       (rst),
      .OPB_ABus      (abus),
      .OPB_BE        (be),
      .OPB_DBus      (dbus),
      .OPB_RNW       (rnw),
      .OPB_select    (sel),
      .OPB_seqAddr   (seq),
      .Sl_DBus       (sl_dbus),
      .Sl_xferAck    (ack),
      .Sl_errAck     (err_ack),
      .Sl_retry      (retry),
      .Sl_toutSup    (tout),
      .user_data_out (udo),
      .user_wr_stb   (stb),
      .user_data_in  (udi)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [NC-1:0] exp_stb);
      for (int i = 0; i < NC; i++) begin
         check($sformatf("%s_word%0d", tag, i), udo[32*i +: 32], m_ctrl[i]);
      end
      check({tag, "_stb"}, 32'(stb), 32'(exp_stb));
      check({tag, "_err"}, {29'd0, err_ack, retry, tout}, 32'd0);
   endtask

   function automatic bit in_window(input logic [31:0] addr);
      return (addr >= BASE) && (addr <= HIGH);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int unsigned idx;
      idx = (addr - BASE) / 4;
      if (idx < NC) return m_ctrl[idx];
      if (idx < NC + NS) return udi[32*(idx-NC) +: 32];
      return 32'd0;
   endfunction

   // One isolated transaction: select for one edge, then check ACK, TURN and IDLE cycles.
   task automatic do_xfer(input logic [31:0] addr, input bit rd, input logic [0:3] ben,
                          input logic [0:31] wd);
      logic [31:0]   exp_rd;
      logic [NC-1:0] exp_stb;
      int unsigned   idx;
      bit            hit;
      hit = in_window(addr);
      idx = (addr - BASE) / 4;
      @(negedge clk);
      abus = addr; rnw = rd; be = ben; dbus = wd; sel = 1'b1;
      exp_rd = (rd && hit) ? model_read(addr) : 32'd0;
      @(negedge clk);
      sel = 1'b0; rnw = 1'b1; dbus = $urandom;
      udi = {$urandom, $urandom};
      check("ack_cycle", 32'(ack), 32'(hit));
      check("rdata_ack", sl_dbus, exp_rd);
      check("stb_ack", 32'(stb), 32'd0);
      exp_stb = '0;
      if (hit && !rd && idx < NC) begin
         for (int b = 0; b < 4; b++) begin
            if (ben[b]) m_ctrl[idx][8*b +: 8] = wd[8*b +: 8];
         end
         exp_stb[idx] = 1'b1;
      end
      @(negedge clk);
      check("ack_turn", 32'(ack), 32'd0);
      check("rdata_turn", sl_dbus, 32'd0);
      check_outputs("turn", exp_stb);
      @(negedge clk);
      check("ack_idle", 32'(ack), 32'd0);
      check("stb_idle", 32'(stb), 32'd0);
   endtask

   initial begin
      logic [31:0] addr;
      int unsigned r;
      rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
      udi = {32'h12345678, 32'h0BADF00D};
      for (int i = 0; i < NC; i++) m_ctrl[i] = RSTV;
      repeat (3) @(negedge clk);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_dbus", sl_dbus, 32'd0);
      check_outputs("reset", '0);
      rst = 1'b0;

      // Full-word write, partial write onto a cleared word, status read.
      do_xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF);
      check("deadbeef", udo[63:32], 32'hDEADBEEF);
      do_xfer(BASE, 1'b0, 4'b1111, 32'h00000000);
      do_xfer(BASE, 1'b0, 4'b0100, 32'h11223344);
      check("partial", udo[31:0], 32'h00220000);
      udi = {32'h12345678, 32'h0BADF00D};
      do_xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0);
      do_xfer(BASE + 32'h1, 1'b1, 4'b0000, 32'h0);
      do_xfer(BASE + 32'h14, 1'b0, 4'b1111, 32'hFFFFFFFF);
      do_xfer(BASE + 32'h18, 1'b0, 4'b1111, 32'hFFFFFFFF);
      do_xfer(BASE + 32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF);
      do_xfer(BASE + 32'hF0, 1'b1, 4'b1111, 32'h0);
      do_xfer(32'h01001200, 1'b1, 4'b1111, 32'h0);
      do_xfer(BASE - 32'h4, 1'b0, 4'b1111, 32'hFFFFFFFF);
      do_xfer(BASE + 32'h8, 1'b0, 4'b1001, 32'hCAFE00BE);

      // Select held for six edges: acks land exactly three cycles apart.
      @(negedge clk);
      abus = BASE + 32'h8; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("held_ack%0d", c), 32'(ack), 32'((c % 3) == 0));
         check($sformatf("held_dbus%0d", c), sl_dbus, ((c % 3) == 0) ? m_ctrl[2] : 32'd0);
      end
      sel = 1'b0;
      @(negedge clk);

      // Reset during the ACK of a write: write dropped, no strobe.
      do_xfer(BASE + 32'hC, 1'b0, 4'b1111, 32'h0F0F0F0F);
      @(negedge clk);
      abus = BASE + 32'hC; rnw = 1'b0; be = 4'b1111; dbus = 32'h13572468; sel = 1'b1;
      @(negedge clk);
      sel = 1'b0;
      check("rst_in_ack_ack", 32'(ack), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) m_ctrl[i] = RSTV;
      check("rst_in_ack_ack_after", 32'(ack), 32'd0);
      check_outputs("rst_in_ack", '0);
      do_xfer(BASE + 32'hC, 1'b1, 4'b1111, 32'h0);

      // Reset coincident with a hit: reset wins, no ack.
      @(negedge clk);
      abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h55555555; sel = 1'b1; rst = 1'b1;
      @(negedge clk);
      sel = 1'b0; rst = 1'b0;
      check("rst_hit_ack", 32'(ack), 32'd0);
      @(negedge clk);
      check("rst_hit_ack2", 32'(ack), 32'd0);
      check_outputs("rst_hit", '0);

      // Randomized traffic, mostly into the mapped words.
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       addr = BASE + 32'($urandom_range(0, 27));
         else if (r < 8)  addr = BASE + 32'($urandom_range(0, 255));
         else if (r == 8) addr = HIGH + 32'd1 + 32'($urandom_range(0, 255));
         else             addr = BASE - 32'd1 - 32'($urandom_range(0, 255));
         udi = {$urandom, $urandom};
         do_xfer(addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opb_register_bank.md
Name: opb_register_bank

Overview:
- Parametrised OPB slave holding NUM_CTRL PPC-writable control registers and NUM_STAT read-only status words, all on one clock.
- Successor to the single-word ppc2simulink register.
- Adds a multi-word address window, byte-enable writes, readback of every word, per-register write strobes, and reset defaults.
- Sits on the XPS OPB bus between PowerPC software and Simulink user logic.

Parameters:
- C_BASEADDR, 32'h01001100, first byte address of window (word aligned).
- C_HIGHADDR, 32'h010011FF, last byte address of window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 supported.
- NUM_CTRL, 4, writable registers at word offsets 0..NUM_CTRL-1 (1..32).
- NUM_STAT, 2, read-only words at offsets NUM_CTRL..NUM_CTRL+NUM_STAT-1 (0..32).
- CTRL_RESET, 32'h00000000, reset value of every control register.

Ports:
- OPB_Clk  in  1  sole clock; bus and user side.
- OPB_Rst  in  1  synchronous active-high reset.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] = DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transaction valid.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; all zero outside the ack cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0.
- user_data_out  out  [NUM_CTRL*32-1:0]  control register i on bits [32i+31:32i].
- user_wr_stb  out  [NUM_CTRL-1:0]  one-cycle pulse when register i is written.
- user_data_in  in  [NUM_STAT*32-1:0]  status word j on bits [32j+31:32j].

Behaviour:
- Reset (synchronous, OPB_Rst=1 at edge):
  - FSM goes to IDLE; pending transactions are dropped, no ack is issued.
  - Sl_xferAck=0, Sl_DBus=0, user_wr_stb=0.
  - All control registers take CTRL_RESET.
- hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
- idx = (OPB_ABus - C_BASEADDR) >> 2. Byte offset bits [1:0] are ignored.
- FSM states IDLE, ACK, TURN:
  - IDLE: on hit, latch idx, RNW, BE and DBus, then go to ACK. Otherwise stay in IDLE.
  - ACK: Sl_xferAck=1 for exactly this cycle; go to TURN.
  - TURN: dead cycle, no hit is evaluated, so select still high after ack cannot retrigger; go to IDLE.
  - Minimum transaction spacing is 3 cycles. Latency is select-sampled edge to ack = 1 cycle.
- Write (latched RNW=0) with idx < NUM_CTRL:
  - At the edge ending ACK, each byte b with BE[b]=1 replaces big-endian byte b (OPB bits [8b:8b+7], register bits [31-8b:24-8b]). Other bytes are kept.
  - user_wr_stb[idx]=1 during TURN, the first cycle the new value is visible on user_data_out.
  - A strobe fires even when BE=4'b0000; the register is unchanged in that case.
- Write to a status index or to an unmapped index inside the window: acked, no effect, no strobe.
- Read:
  - During ACK, Sl_DBus carries the control register (idx < NUM_CTRL), or user_data_in word idx-NUM_CTRL sampled at the IDLE->ACK edge, or 0 for unmapped indices.
  - Sl_DBus is 0 in every other cycle (wired-OR bus).
- Addresses outside the window are never acked and no state changes.
- Simultaneous OPB_Rst and hit: reset wins, no ack.
- Reset asserted during ACK or TURN: ack deasserted from the next cycle, any pending write is discarded.

Decomposition:
- Package opb_reg_pkg:
  - FSM state enum (IDLE, ACK, TURN).
  - Constants OPB_DW=32 and BYTES_PER_WORD=4.
  - Byte-lane mapping helper function.
- Sub-module opb_slave_handshake:
  - Contains address-window compare, FSM, and latching of idx/RNW/BE/DBus.
  - Exports ack, wr_en, rd_en and idx.
- The top level holds the register array, byte-enable merge, strobes and read mux.

Test Plan:
- Reset with CTRL_RESET=32'hA5A5A5A5 -> every user_data_out word = A5A5A5A5; Sl_xferAck=0; Sl_DBus=0.
- Write 0x01001104 data 0xDEADBEEF, BE=1111 -> ack one cycle after select; user_data_out[63:32]=DEADBEEF with user_wr_stb=4'b0010 in the same single cycle.
- Partial write to 0x01001100 data 0x11223344, BE=0100, register previously 0 -> register = 0x00220000.
- Read 0x01001110 with user_data_in[31:0]=0x0BADF00D -> Sl_DBus=0BADF00D only in the ack cycle, 0 before and after.
- Select held high 6 cycles at 0x01001108 -> acks exactly 3 cycles apart; an unmapped read at 0x010011F0 returns 0 with ack; access at 0x01001200 -> no ack.
- Reset during ACK of a write -> register keeps reset value; no strobe; FSM back in IDLE.
